// File: rtl/mlaccel_qpi_master_if.sv
// Byte-level command/response handshake between an accelerator client and
// the QPI master. The client drives commands; the QPI master returns read bytes.
interface mlaccel_qpi_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_wdata;
    logic       cmd_last;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_write, cmd_wdata, cmd_last,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_wdata, cmd_last,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mlaccel_qpi_master.sv
// QPI (quad I/O) byte master: one qpi_clk period per byte, high nibble on the
// rising edge, low nibble on the falling edge, with chip-select framing.
module mlaccel_qpi_master #(
    parameter int CLKDIV = 2,
    parameter int CS_GAP = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    mlaccel_qpi_master_if.slave        cmd,
    output logic                       busy,
    output logic                       qpi_csb,
    output logic                       qpi_clk,
    output logic [3:0]                 qpi_io_do,
    output logic [3:0]                 qpi_io_oe,
    input  logic [3:0]                 qpi_io_di
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_STALL = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;
    localparam logic [2:0] ST_GAP   = 3'd6;

    localparam logic [7:0] PHASE_LOAD = 8'(CLKDIV - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(CS_GAP - 1);

    logic [2:0] state_r;
    logic [2:0] state_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic [7:0] byte_r;
    logic [7:0] byte_nxt_s;
    logic       write_r;
    logic       write_nxt_s;
    logic       last_r;
    logic       last_nxt_s;
    logic [3:0] rd_hi_r;

    logic       csb_r;
    logic       clk_r;
    logic       oe_r;
    logic [3:0] do_r;
    logic       ready_r;
    logic       busy_r;
    logic       rsp_valid_r;
    logic [7:0] rsp_data_r;

    logic       csb_nxt_s;
    logic       clk_nxt_s;
    logic       oe_nxt_s;
    logic [3:0] do_nxt_s;
    logic       ready_nxt_s;
    logic       busy_nxt_s;

    logic       accept_s;
    logic       phase_end_s;

    assign accept_s    = cmd.cmd_valid && ready_r;
    assign phase_end_s = (cnt_r == 8'd0);

    // Next-state, phase counter and command latch.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        byte_nxt_s  = byte_r;
        write_nxt_s = write_r;
        last_nxt_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SETUP;
                    cnt_nxt_s   = PHASE_LOAD;
                    byte_nxt_s  = cmd.cmd_wdata;
                    write_nxt_s = cmd.cmd_write;
                    last_nxt_s  = cmd.cmd_last;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (phase_end_s) begin
                    state_nxt_s = (state_r == ST_SETUP) ? ST_LOW : ST_HIGH;
                    cnt_nxt_s   = PHASE_LOAD;
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end
            end
            ST_HIGH: begin
                if (!phase_end_s) begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end else if (last_r) begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = PHASE_LOAD;
                end else if (accept_s) begin
                    // Chained byte: go straight to LOW so clock-low time stays CLKDIV.
                    state_nxt_s = ST_LOW;
                    cnt_nxt_s   = PHASE_LOAD;
                    byte_nxt_s  = cmd.cmd_wdata;
                    write_nxt_s = cmd.cmd_write;
                    last_nxt_s  = cmd.cmd_last;
                end else begin
                    state_nxt_s = ST_STALL;
                end
            end
            ST_STALL: begin
                if (accept_s) begin
                    state_nxt_s = ST_LOW;
                    cnt_nxt_s   = PHASE_LOAD;
                    byte_nxt_s  = cmd.cmd_wdata;
                    write_nxt_s = cmd.cmd_write;
                    last_nxt_s  = cmd.cmd_last;
                end else begin
                    state_nxt_s = ST_STALL;
                end
            end
            ST_HOLD: begin
                if (phase_end_s) begin
                    state_nxt_s = ST_GAP;
                    cnt_nxt_s   = GAP_LOAD;
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end
            end
            ST_GAP: begin
                if (phase_end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // Output values for the upcoming state, so every pad/handshake output is a flop.
    always_comb begin
        csb_nxt_s   = 1'b1;
        clk_nxt_s   = 1'b0;
        oe_nxt_s    = oe_r;
        do_nxt_s    = do_r;
        ready_nxt_s = 1'b0;
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        case (state_nxt_s)
            ST_IDLE: begin
                oe_nxt_s    = 1'b0;
                do_nxt_s    = 4'h0;
                ready_nxt_s = 1'b1;
            end
            ST_SETUP, ST_LOW: begin
                csb_nxt_s = 1'b0;
                oe_nxt_s  = write_nxt_s;
                if (write_nxt_s) begin
                    do_nxt_s = byte_nxt_s[7:4];
                end else begin
                    do_nxt_s = do_r;
                end
            end
            ST_HIGH: begin
                csb_nxt_s   = 1'b0;
                clk_nxt_s   = 1'b1;
                oe_nxt_s    = write_nxt_s;
                ready_nxt_s = (cnt_nxt_s == 8'd0) && !last_nxt_s;
                if (write_nxt_s) begin
                    do_nxt_s = byte_nxt_s[3:0];
                end else begin
                    do_nxt_s = do_r;
                end
            end
            ST_STALL: begin
                csb_nxt_s   = 1'b0;
                ready_nxt_s = 1'b1;
            end
            ST_HOLD: begin
                csb_nxt_s = 1'b0;
            end
            ST_GAP: begin
                oe_nxt_s = 1'b0;
            end
            default: begin
                oe_nxt_s = 1'b0;
                do_nxt_s = 4'h0;
            end
        endcase
    end

    // State, phase counter and latched command registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            byte_r  <= 8'h00;
            write_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            byte_r  <= byte_nxt_s;
            write_r <= write_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Registered pad and handshake outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            csb_r   <= 1'b1;
            clk_r   <= 1'b0;
            oe_r    <= 1'b0;
            do_r    <= 4'h0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            csb_r   <= csb_nxt_s;
            clk_r   <= clk_nxt_s;
            oe_r    <= oe_nxt_s;
            do_r    <= do_nxt_s;
            ready_r <= ready_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Read capture: high nibble held aside so rsp_data only changes with rsp_valid.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_hi_r     <= 4'h0;
            rsp_data_r  <= 8'h00;
            rsp_valid_r <= 1'b0;
        end else begin
            if ((state_r == ST_LOW) && phase_end_s) begin
                rd_hi_r <= qpi_io_di;
            end
            if ((state_r == ST_HIGH) && phase_end_s && !write_r) begin
                rsp_data_r  <= {rd_hi_r, qpi_io_di};
                rsp_valid_r <= 1'b1;
            end else begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign cmd.cmd_ready = ready_r;
    assign cmd.rsp_valid = rsp_valid_r;
    assign cmd.rsp_data  = rsp_data_r;
    assign busy          = busy_r;
    assign qpi_csb       = csb_r;
    assign qpi_clk       = clk_r;
    assign qpi_io_do     = do_r;
    assign qpi_io_oe     = {4{oe_r}};

endmodule
